// File: rtl/stream_demux.sv
// stream_demux: one-to-many valid/ready router with one registered slot per output.
// A multi-hot select broadcasts a beat atomically. An all-zero select discards it.
// Optional feature: define STREAM_DEMUX_DROP_COUNT_EN to add a saturating 16-bit
// drop_count output that counts discarded beats.

module stream_demux #(
    parameter int Outputs = 4,
    parameter int Width   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    input  logic             in_sel    [Outputs],
    output logic             out_valid [Outputs],
    input  logic             out_ready [Outputs],
    output logic [Width-1:0] out_data  [Outputs]
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    logic accept;
    logic load [Outputs];

    // Input is ready only when every selected slot is empty or being drained this cycle.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < Outputs; i++) begin
            if (in_sel[i] && out_valid[i] && !out_ready[i]) begin
                in_ready = 1'b0;
            end
        end
    end

    // An accepted beat loads every selected slot together, so broadcasts never split.
    always_comb begin
        accept = in_valid && in_ready;
        for (int i = 0; i < Outputs; i++) begin
            load[i] = accept && in_sel[i];
        end
    end

    // Per-slot register: a new load takes priority over a drain, giving full throughput.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Outputs; i++) begin
            if (!rst_n) begin
                out_valid[i] <= 1'b0;
                out_data[i]  <= '0;
            end else if (load[i]) begin
                out_valid[i] <= 1'b1;
                out_data[i]  <= in_data;
            end else if (out_ready[i]) begin
                out_valid[i] <= 1'b0;
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_COUNT_EN
    logic sel_none;

    // Detect a beat with no destination; such beats are accepted and discarded.
    always_comb begin
        sel_none = 1'b1;
        for (int i = 0; i < Outputs; i++) begin
            if (in_sel[i]) begin
                sel_none = 1'b0;
            end
        end
    end

    // Count discarded beats, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (accept && sel_none && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed scoreboard bench for stream_demux.
// Define STREAM_DEMUX_DROP_COUNT_EN to also check the drop counter.

module tb_stream_demux;

    localparam int Outputs = 4;
    localparam int Width   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             in_sel    [Outputs];
    logic             out_valid [Outputs];
    logic             out_ready [Outputs];
    logic [Width-1:0] out_data  [Outputs];
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    logic [15:0]      drop_count;
    logic [15:0]      dropModel;
`endif

    logic [Width-1:0] expQ     [Outputs][$];
    logic [Width-1:0] lastData [Outputs];
    int               testCount = 0;
    int               failCount = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    stream_demux #(
        .Outputs(Outputs),
        .Width  (Width)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    // Compare every slot (and the drop counter) against the scoreboard model.
    task automatic checkOutput();
        logic expV;
        for (int i = 0; i < Outputs; i++) begin
            expV = (expQ[i].size() != 0);
            testCount++;
            assert (out_valid[i] === expV) else begin
                failCount++;
                $error("[TB] FAIL out_valid[%0d] observed=%0b expected=%0b", i, out_valid[i], expV);
            end
            testCount++;
            assert (out_data[i] === lastData[i]) else begin
                failCount++;
                $error("[TB] FAIL out_data[%0d] observed=%02h expected=%02h", i, out_data[i], lastData[i]);
            end
        end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        testCount++;
        assert (drop_count === dropModel) else begin
            failCount++;
            $error("[TB] FAIL drop_count observed=%04h expected=%04h", drop_count, dropModel);
        end
`endif
    endtask

    // Drive one cycle of stimulus, check in_ready and consumed beats, update the scoreboard.
    task automatic applyStimulus(input logic v, input logic [3:0] sel,
                                 input logic [7:0] d, input logic [3:0] rdy);
        logic expReady;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = v;
        in_data  = d;
        for (int i = 0; i < Outputs; i++) begin
            in_sel[i]    = sel[i];
            out_ready[i] = rdy[i];
        end
        #1;
        expReady = 1'b1;
        for (int i = 0; i < Outputs; i++) begin
            if (sel[i] && (expQ[i].size() != 0) && !rdy[i]) expReady = 1'b0;
        end
        testCount++;
        assert (in_ready === expReady) else begin
            failCount++;
            $error("[TB] FAIL in_ready observed=%0b expected=%0b", in_ready, expReady);
        end
        for (int i = 0; i < Outputs; i++) begin
            if (rdy[i] && (expQ[i].size() != 0)) begin
                testCount++;
                assert (out_data[i] === expQ[i][0]) else begin
                    failCount++;
                    $error("[TB] FAIL consumed[%0d] observed=%02h expected=%02h", i, out_data[i], expQ[i][0]);
                end
                void'(expQ[i].pop_front());
            end
        end
        if (v && expReady) begin
            for (int i = 0; i < Outputs; i++) begin
                if (sel[i]) begin
                    expQ[i].push_back(d);
                    lastData[i] = d;
                end
            end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
            if ((sel == 4'b0000) && (dropModel != 16'hFFFF)) dropModel = dropModel + 16'd1;
`endif
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // One-cycle reset with a beat for output 3 pending; then check the idle in_ready.
    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < Outputs; i++) begin
            in_sel[i]    = (i == 3);
            out_ready[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < Outputs; i++) begin
            expQ[i].delete();
            lastData[i] = '0;
        end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        dropModel = '0;
`endif
        checkOutput();
        in_valid = 1'b0;
        for (int i = 0; i < Outputs; i++) in_sel[i] = 1'b1;
        #1;
        testCount++;
        assert (in_ready === 1'b1) else begin
            failCount++;
            $error("[TB] FAIL idle_in_ready observed=%0b expected=1", in_ready);
        end
    endtask

    // Directed test sequence.
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < Outputs; i++) begin
            in_sel[i]    = 1'b0;
            out_ready[i] = 1'b0;
            lastData[i]  = '0;
        end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        dropModel = '0;
`endif

        doReset();
        applyStimulus(1'b1, 4'b1111, 8'h5A, 4'b0000);
        doReset();

        applyStimulus(1'b1, 4'b0100, 8'hA5, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 8'hB6, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 8'hB6, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 8'hB6, 4'b0100);
        applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0100);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 4'b0010, 8'(k), 4'b0010);
        end
        applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0010);

        applyStimulus(1'b1, 4'b0001, 8'h11, 4'b0000);
        applyStimulus(1'b1, 4'b0011, 8'h3C, 4'b0000);
        applyStimulus(1'b1, 4'b0011, 8'h3C, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 8'h00, 4'b0011);

        applyStimulus(1'b1, 4'b1000, 8'h44, 4'b0000);
        applyStimulus(1'b1, 4'b0001, 8'h66, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 8'h00, 4'b1001);

        doReset();
        applyStimulus(1'b1, 4'b0001, 8'h21, 4'b0000);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0000, 8'hEE, 4'b0000);

`ifdef STREAM_DEMUX_DROP_COUNT_EN
        begin
            int n;
            @(negedge clk);
            rst_n    = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'hEE;
            for (int i = 0; i < Outputs; i++) begin
                in_sel[i]    = 1'b0;
                out_ready[i] = 1'b0;
            end
            n = 32'hFFFE - int'(dropModel);
            repeat (n) @(posedge clk);
            dropModel = 16'hFFFE;
            #1;
            checkOutput();
            for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0000, 8'hEE, 4'b0000);
        end
`endif

        applyStimulus(1'b1, 4'b1000, 8'h44, 4'b0000);
        applyStimulus(1'b1, 4'b1000, 8'h55, 4'b0000);
        doReset();
        applyStimulus(1'b1, 4'b1000, 8'h77, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 8'h00, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- One-to-many stream router: the distribution-side counterpart of the one-hot AND-OR mux.
- Takes one valid/ready input stream with a one-hot/multi-hot select and delivers each accepted beat into per-output registered slots.
- Multi-hot select broadcasts the beat. All-zero select discards it.
- Sits between a single producer (e.g. writeback/result bus) and multiple consumers, providing one pipeline stage of buffering per output.

Parameters:
- Outputs, 4, number of output streams (>=1)
- Width, 8, payload width in bits (>=1)

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready
- in_data  input  Width  input payload
- in_sel  input  1 x [Outputs] (unpacked)  destination select; bit i targets output i
- out_valid  output  1 x [Outputs] (unpacked)  slot i holds a beat
- out_ready  input  1 x [Outputs] (unpacked)  consumer i takes the beat when out_valid[i] && out_ready[i]
- out_data  output  Width x [Outputs] (unpacked)  slot i payload

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - all out_valid[i] -> 0.
  - out_data[i] -> 0.
  - Any held beat is lost; no partial broadcast survives.
  - in_ready is combinational and evaluates to 1 while all slots are empty.
- Storage: one slot per output (valid bit + Width data register). No other state, apart from the optional counter.
- Slot i is free this cycle when !out_valid[i] || out_ready[i], so a full slot being drained can accept in the same cycle.
- in_ready = AND over all i with in_sel[i]=1 of free[i]. If in_sel is all-zero, in_ready=1.
- in_ready depends combinationally on in_sel and out_ready only, never on in_valid.
- Accept (in_valid && in_ready): every slot i with in_sel[i]=1 loads in_data and sets out_valid[i]=1 at the next edge.
- Broadcast is atomic: either all selected slots load, or none.
- Dequeue: out_valid[i] && out_ready[i] with no load into slot i -> out_valid[i]=0 next cycle. out_data[i] holds its last value.
- Simultaneous dequeue and load on slot i: out_valid[i] stays 1 and out_data[i] takes the new beat. Full throughput, one beat per cycle per output.
- Latency: accepted beat visible on out_valid/out_data exactly 1 cycle after acceptance.
- Ordering per output is preserved trivially (single slot).
- All-zero in_sel with in_valid=1: beat accepted and discarded; no slot changes.
- in_valid=0: in_sel and in_data are ignored. Slots only drain.
- Outputs are independent. A stalled consumer blocks only beats whose in_sel includes it.
- out_valid[i], once 1, stays 1 with stable out_data[i] until out_ready[i]. No combinational path from in_* to out_valid/out_data.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_COUNT_EN
- When defined:
  - extra port drop_count output 16 bits.
  - Increments by 1 at each edge where in_valid && in_ready && in_sel all-zero.
  - Saturates at 16'hFFFF (no wrap).
  - Reset to 0 by rst_n.
- When undefined: port absent; discarded beats leave no trace. All other behaviour identical.

Test Plan:
- Reset with slots full, rst_n=0 for 1 cycle -> all out_valid=0, out_data=0; in_valid=0 with all out_ready=0 gives in_ready=1.
- Single route: in_sel={0,0,1,0}, in_data=8'hA5, out_ready[2]=0 -> next cycle out_valid[2]=1, out_data[2]=A5, others 0. Second beat to output 2 sees in_ready=0 and is held until out_ready[2]=1.
- Back-to-back throughput: out_ready[1]=1 constantly, send 8'h01..8'h08 to output 1 on consecutive cycles -> in_ready=1 every cycle, out_data[1] = 01..08 one per cycle, 1-cycle latency.
- Broadcast blocking: in_sel={1,1,0,0}, slot 0 full with out_ready[0]=0, slot 1 empty -> in_ready=0 and slot 1 not loaded. Raise out_ready[0]=1 -> beat 8'h3C lands in both slots in the same cycle.
- Drop: in_sel all-zero, in_valid=1 for 3 cycles -> in_ready=1, no out_valid change. With STREAM_DEMUX_DROP_COUNT_EN, drop_count=3. Preload 16'hFFFE and drop 3 more -> drop_count=16'hFFFF.
- Reset mid-stream: slot 3 full, beat to output 3 pending, assert rst_n=0 -> out_valid[3]=0 next cycle; after release, a new beat 8'h77 routes normally.
